mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Load/store stage directly upstream of the register write-back stage.
- Accepts one executed instruction at a time and runs its data-memory transaction over a req/gnt/rvalid bus.
- Aligns and sign/zero-extends load data.
- Presents a registered (rd_addr, rd_write_en, rd_data) triple for write-back; non-memory instructions pass through with one cycle of latency.

Parameters:
- XLEN, 32, data/address width; equals `XLEN.
- REG_ADDR_W, 5, register address width; equals `SYS_REGS_WIDTH.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  reset; synchronous, active-high.
- halt_i  in  1  halt; blocks acceptance of new instructions.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept; transfer occurs when valid_i & ready_o.
- is_load_i  in  1  instruction is a load.
- is_store_i  in  1  instruction is a store.
- mem_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_result_i  in  XLEN  memory address, or rd data for non-memory ops.
- store_data_i  in  XLEN  rs2 value for stores.
- rd_addr_i  in  REG_ADDR_W  destination register.
- rd_write_en_i  in  1  instruction writes rd.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  XLEN  word-aligned address, addr[1:0] = 0.
- dmem_be_o  out  XLEN/8  byte enables.
- dmem_wdata_o  out  XLEN  lane-shifted store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  load response valid.
- dmem_rdata_i  in  XLEN  load response word.
- dmem_err_i  in  1  bus error, qualified by rvalid_i.
- valid_o  out  1  one-cycle pulse: instruction retired from the stage.
- rd_addr_o  out  REG_ADDR_W  to write-back.
- rd_write_en_o  out  1  to write-back.
- rd_data_o  out  XLEN  to write-back.
- misalign_o  out  1  pulse with valid_o: misaligned access.
- bus_err_o  out  1  pulse with valid_o: load bus error.

Behaviour:
- Reset values: all outputs 0, FSM IDLE. Reset mid-transaction drops dmem_req_o the next cycle. An rvalid arriving in IDLE is ignored.
- ready_o = (state==IDLE) & !halt_i. While halt_i is high, an accepted transaction still completes.
- Non-memory op accepted at cycle T: at T+1, valid_o=1, rd_data_o=alu_result_i, rd_write_en_o=rd_write_en_i & (rd_addr_i!=0).
- Misalignment check at acceptance: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Response at T+1: valid_o=1, misalign_o=1, rd_write_en_o=0.
  - No bus request is issued.
- FSM states and transitions:
  - IDLE -> REQ on an accepted aligned load or store; all request fields are registered.
  - REQ: dmem_req_o=1, request fields held stable until dmem_gnt_i.
    - Store + gnt -> IDLE, and valid_o pulses the next cycle with rd_write_en_o=0.
    - Load + gnt -> WAIT.
  - WAIT: on dmem_rvalid_i -> IDLE, and the registered result is valid the next cycle.
- A gnt arriving in the same cycle req rises is legal. Minimum load latency is acceptance T -> valid_o at T+3, given gnt at T+1 and rvalid at T+2.
- Store lanes, with off = addr[1:0]:
  - B: be = 1 << off; wdata = byte replicated across all 4 lanes.
  - H: be = 0011 << off; wdata = halfword replicated.
  - W: be = 1111.
- Load extraction: shift rdata right by 8*off, then
  - B: sign-extend bit 7.
  - BU: zero-extend from bit 7.
  - H: sign-extend bit 15.
  - HU: zero-extend from bit 15.
  - W: whole word.
- dmem_err_i with rvalid: valid_o=1, bus_err_o=1, rd_write_en_o=0.
- rd_addr_o and rd_data_o hold their last value between valid_o pulses. rd_write_en_o is 0 whenever valid_o is 0.
- An unsupported mem_size_i on a memory op is treated as W.
- is_load_i and is_store_i both set: the instruction is treated as a load.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 size constants MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU.
  - The FSM state enum {IDLE, REQ, WAIT}.
- One combinational sub-module, load_align, does rdata shift and extend from (rdata, off, size).

Test Plan:
- Non-memory op: alu_result=0x0000_1234, rd=5, we=1 -> valid_o at T+1, rd_data_o=0x1234, rd_write_en_o=1. Same op with rd=0 -> rd_write_en_o=0.
- LB at addr 0x103, rdata=0x80FF_0000, gnt after 2 cycles, rvalid 1 cycle later -> rd_data_o=0xFFFF_FF80. The same access as LBU -> 0x0000_0080.
- SH at addr 0x202, data 0xABCD_5678 -> dmem_addr_o=0x200, be=1100, wdata=0x5678_5678. req is held until gnt, then valid_o fires with rd_write_en_o=0.
- LW at addr 0x101 -> misalign_o=1 at T+1, dmem_req_o never asserted, rd_write_en_o=0.
- Load whose rvalid carries dmem_err_i=1 -> bus_err_o=1, rd_write_en_o=0. Separately: halt_i held high keeps ready_o=0 while a load already in WAIT still completes.
- reset_i asserted in WAIT -> the next cycle is IDLE with dmem_req_o=0; a late rvalid is ignored and valid_o stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store stage: funct3 size codes, FSM states
// and small decode helpers used by the datapath.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Any funct3 outside the supported set behaves as a full word access.
  function automatic logic [2:0] norm_size(input logic [2:0] size);
    case (size)
      MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: norm_size = size;
      default:                             norm_size = MEM_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      MEM_H, MEM_HU: is_misaligned = off[0];
      MEM_W:         is_misaligned = (off != 2'b00);
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data alignment: moves the addressed byte/halfword down to bit 0 and
// sign- or zero-extends it according to the access size.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      size,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  // Lane shift followed by extension of the selected field.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (size)
      MEM_B:   data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      MEM_BU:  data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      MEM_H:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      MEM_HU:  data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store stage: issues one data-memory transaction per accepted memory
// instruction and presents a registered write-back triple.
module mem_access
  import mem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  halt_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic [2:0]            mem_size_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [XLEN-1:0]       store_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rd_write_en_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [XLEN-1:0]       dmem_addr_o,
  output logic [XLEN/8-1:0]     dmem_be_o,
  output logic [XLEN-1:0]       dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  input  logic                  dmem_err_i,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  rd_write_en_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  localparam int BE_W = XLEN / 8;

  state_t state;
  state_t state_next;

  logic                  accept;
  logic                  is_mem;
  logic [2:0]            eff_size;
  logic [1:0]            in_off;
  logic                  misaligned;
  logic                  start_req;
  logic [BE_W-1:0]       lane_be;
  logic [XLEN-1:0]       lane_wdata;
  logic [XLEN-1:0]       load_data;

  logic                  req_we;
  logic [XLEN-1:0]       req_addr;
  logic [BE_W-1:0]       req_be;
  logic [XLEN-1:0]       req_wdata;
  logic [1:0]            req_off;
  logic [2:0]            req_size;
  logic [REG_ADDR_W-1:0] req_rd_addr;
  logic                  req_rd_we;

  logic                  valid_next;
  logic [REG_ADDR_W-1:0] rd_addr_next;
  logic                  rd_we_next;
  logic [XLEN-1:0]       rd_data_next;
  logic                  misalign_next;
  logic                  bus_err_next;

  assign ready_o    = (state == IDLE) & ~halt_i;
  assign accept     = valid_i & ready_o;
  assign is_mem     = is_load_i | is_store_i;
  assign eff_size   = norm_size(mem_size_i);
  assign in_off     = alu_result_i[1:0];
  assign misaligned = is_mem & is_misaligned(eff_size, in_off);
  assign start_req  = accept & is_mem & ~misaligned;

  assign dmem_we_o    = req_we;
  assign dmem_addr_o  = req_addr;
  assign dmem_be_o    = req_be;
  assign dmem_wdata_o = req_wdata;

  // Byte enables and replicated store data for the addressed lanes.
  always_comb begin
    case (eff_size)
      MEM_B, MEM_BU: begin
        lane_be    = {{(BE_W-1){1'b0}}, 1'b1} << in_off;
        lane_wdata = {BE_W{store_data_i[7:0]}};
      end
      MEM_H, MEM_HU: begin
        lane_be    = {{(BE_W-2){1'b0}}, 2'b11} << in_off;
        lane_wdata = {(XLEN/16){store_data_i[15:0]}};
      end
      default: begin
        lane_be    = {BE_W{1'b1}};
        lane_wdata = store_data_i;
      end
    endcase
  end

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata (dmem_rdata_i),
    .off   (req_off),
    .size  (req_size),
    .data  (load_data)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; a set is_load_i wins over is_store_i.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_req) state_next = REQ;
        else           state_next = IDLE;
      end
      REQ: begin
        if (dmem_gnt_i) state_next = req_we ? IDLE : WAIT;
        else            state_next = REQ;
      end
      WAIT: begin
        if (dmem_rvalid_i) state_next = IDLE;
        else               state_next = WAIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: bus request plus next values of the write-back triple.
  always_comb begin
    dmem_req_o    = (state == REQ);
    valid_next    = 1'b0;
    rd_addr_next  = rd_addr_o;
    rd_we_next    = 1'b0;
    rd_data_next  = rd_data_o;
    misalign_next = 1'b0;
    bus_err_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept & ~is_mem) begin
          valid_next   = 1'b1;
          rd_addr_next = rd_addr_i;
          rd_data_next = alu_result_i;
          rd_we_next   = rd_write_en_i & (rd_addr_i != {REG_ADDR_W{1'b0}});
        end else if (accept & misaligned) begin
          valid_next    = 1'b1;
          rd_addr_next  = rd_addr_i;
          misalign_next = 1'b1;
        end else begin
          valid_next = 1'b0;
        end
      end
      REQ: begin
        if (dmem_gnt_i & req_we) begin
          valid_next   = 1'b1;
          rd_addr_next = req_rd_addr;
        end else begin
          valid_next = 1'b0;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          valid_next   = 1'b1;
          rd_addr_next = req_rd_addr;
          if (dmem_err_i) begin
            bus_err_next = 1'b1;
          end else begin
            rd_data_next = load_data;
            rd_we_next   = req_rd_we;
          end
        end else begin
          valid_next = 1'b0;
        end
      end
      default: valid_next = 1'b0;
    endcase
  end

  // Request fields captured at acceptance and held until the bus completes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_we      <= 1'b0;
      req_addr    <= {XLEN{1'b0}};
      req_be      <= {BE_W{1'b0}};
      req_wdata   <= {XLEN{1'b0}};
      req_off     <= 2'b00;
      req_size    <= 3'b000;
      req_rd_addr <= {REG_ADDR_W{1'b0}};
      req_rd_we   <= 1'b0;
    end else if (start_req) begin
      req_we      <= ~is_load_i;
      req_addr    <= {alu_result_i[XLEN-1:2], 2'b00};
      req_be      <= lane_be;
      req_wdata   <= lane_wdata;
      req_off     <= in_off;
      req_size    <= eff_size;
      req_rd_addr <= rd_addr_i;
      req_rd_we   <= rd_write_en_i & (rd_addr_i != {REG_ADDR_W{1'b0}});
    end else begin
      req_we      <= req_we;
      req_addr    <= req_addr;
      req_be      <= req_be;
      req_wdata   <= req_wdata;
      req_off     <= req_off;
      req_size    <= req_size;
      req_rd_addr <= req_rd_addr;
      req_rd_we   <= req_rd_we;
    end
  end

  // Registered write-back outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_o       <= 1'b0;
      rd_addr_o     <= {REG_ADDR_W{1'b0}};
      rd_write_en_o <= 1'b0;
      rd_data_o     <= {XLEN{1'b0}};
      misalign_o    <= 1'b0;
      bus_err_o     <= 1'b0;
    end else begin
      valid_o       <= valid_next;
      rd_addr_o     <= rd_addr_next;
      rd_write_en_o <= rd_we_next;
      rd_data_o     <= rd_data_next;
      misalign_o    <= misalign_next;
      bus_err_o     <= bus_err_next;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized operations
// checked against a byte-level reference model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset_i, halt_i, valid_i, ready_o;
  logic        is_load_i, is_store_i;
  logic [2:0]  mem_size_i;
  logic [31:0] alu_result_i, store_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_write_en_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i, dmem_err_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  logic [4:0]  rd_addr_o;
  logic        rd_write_en_o;
  logic [31:0] rd_data_o;
  logic        misalign_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk_i(clk), .reset_i(reset_i), .halt_i(halt_i), .valid_i(valid_i), .ready_o(ready_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .mem_size_i(mem_size_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
    .rd_write_en_i(rd_write_en_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .dmem_err_i(dmem_err_i), .valid_o(valid_o), .rd_addr_o(rd_addr_o),
    .rd_write_en_o(rd_write_en_o), .rd_data_o(rd_data_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Access width in bytes; unsupported codes act as a word.
  function automatic int nbytes_of(input logic [2:0] sz);
    if (sz == 3'b000 || sz == 3'b100)      return 1;
    else if (sz == 3'b001 || sz == 3'b101) return 2;
    else                                   return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [2:0] sz);
    int     n;
    longint v, span;
    logic   sgn;
    n    = nbytes_of(sz);
    sgn  = (sz == 3'b000) || (sz == 3'b001);
    v    = rdata;
    v    = v >> (8 * int'(addr[1:0]));
    span = 64'sd1 <<< (8 * n);
    v    = v % span;
    if (sgn && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] addr, input int n);
    int off;
    off    = int'(addr[1:0]);
    ref_be = 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) ref_be[i] = 1'b1;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int n);
    ref_wdata = 32'h0;
    for (int i = 0; i < 4; i++) ref_wdata[8*i +: 8] = d[8*(i % n) +: 8];
  endfunction

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic we);
    valid_i = 1'b1; is_load_i = ld; is_store_i = st; mem_size_i = sz;
    alu_result_i = addr; store_data_i = sdata; rd_addr_i = rd; rd_write_en_i = we;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
  endtask

  // One complete operation, from acceptance through retirement and the cycle after.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic we, input int gdly, input int rdly,
                        input logic [31:0] rdata, input logic err, input logic halt_mid);
    logic        is_mem, mis, wrote;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    int          n;
    is_mem = ld | st;
    n      = nbytes_of(sz);
    mis    = is_mem && ((addr % n) != 0);
    wrote  = 1'b0;
    exp_data = 32'h0;
    exp_rd   = rd;
    @(negedge clk);
    check("ready_before", 32'(ready_o), 32'd1);
    drive_op(ld, st, sz, addr, sdata, rd, we);
    @(negedge clk);
    idle_inputs();
    if (!is_mem) begin
      check("alu_valid", 32'(valid_o), 32'd1);
      check("alu_data", rd_data_o, addr);
      check("alu_rd", 32'(rd_addr_o), 32'(rd));
      check("alu_we", 32'(rd_write_en_o), 32'(we && rd != 5'd0));
      check("alu_misalign", 32'(misalign_o), 32'd0);
      check("alu_noreq", 32'(dmem_req_o), 32'd0);
      wrote = 1'b1; exp_data = addr;
    end else if (mis) begin
      check("mis_valid", 32'(valid_o), 32'd1);
      check("mis_flag", 32'(misalign_o), 32'd1);
      check("mis_we", 32'(rd_write_en_o), 32'd0);
      check("mis_noreq", 32'(dmem_req_o), 32'd0);
    end else begin
      check("req_up", 32'(dmem_req_o), 32'd1);
      check("req_we", 32'(dmem_we_o), 32'(!ld));
      check("req_addr", dmem_addr_o, {addr[31:2], 2'b00});
      check("req_be", 32'(dmem_be_o), 32'(ref_be(addr, n)));
      if (!ld) check("req_wdata", dmem_wdata_o, ref_wdata(sdata, n));
      check("req_novalid", 32'(valid_o), 32'd0);
      for (int k = 0; k < gdly; k++) begin
        @(negedge clk);
        check("req_held", 32'(dmem_req_o), 32'd1);
        check("addr_held", dmem_addr_o, {addr[31:2], 2'b00});
        check("wait_novalid", 32'(valid_o), 32'd0);
      end
      dmem_gnt_i = 1'b1;
      @(negedge clk);
      dmem_gnt_i = 1'b0;
      if (!ld) begin
        check("st_valid", 32'(valid_o), 32'd1);
        check("st_we", 32'(rd_write_en_o), 32'd0);
        check("st_req_drop", 32'(dmem_req_o), 32'd0);
        check("st_errflags", 32'({misalign_o, bus_err_o}), 32'd0);
      end else begin
        check("ld_req_drop", 32'(dmem_req_o), 32'd0);
        check("ld_novalid", 32'(valid_o), 32'd0);
        if (halt_mid) begin
          halt_i = 1'b1;
          #1;
          check("halt_ready", 32'(ready_o), 32'd0);
        end
        for (int k = 0; k < rdly; k++) @(negedge clk);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata; dmem_err_i = err;
        @(negedge clk);
        dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
        check("ld_valid", 32'(valid_o), 32'd1);
        check("ld_buserr", 32'(bus_err_o), 32'(err));
        check("ld_we", 32'(rd_write_en_o), 32'(!err && we && rd != 5'd0));
        check("ld_rd", 32'(rd_addr_o), 32'(rd));
        if (!err) begin
          check("ld_data", rd_data_o, ref_load(rdata, addr, sz));
          wrote = 1'b1; exp_data = ref_load(rdata, addr, sz);
        end
        if (halt_mid) begin
          check("halt_ready_done", 32'(ready_o), 32'd0);
          halt_i = 1'b0;
        end
      end
    end
    @(negedge clk);
    check("valid_drop", 32'(valid_o), 32'd0);
    check("we_drop", 32'(rd_write_en_o), 32'd0);
    if (wrote) begin
      check("data_hold", rd_data_o, exp_data);
      check("rd_hold", 32'(rd_addr_o), 32'(exp_rd));
    end
  endtask

  initial begin
    logic        ld, st, err;
    logic [2:0]  sz;
    logic [31:0] addr, sdata, rdata;
    int          kind, n;

    reset_i = 1'b1; halt_i = 1'b0; idle_inputs();
    mem_size_i = 3'b000; alu_result_i = 32'h0; store_data_i = 32'h0;
    rd_addr_i = 5'd0; rd_write_en_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_rd", 32'(rd_addr_o), 32'd0);
    check("rst_we", 32'(rd_write_en_o), 32'd0);
    check("rst_data", rd_data_o, 32'd0);
    check("rst_flags", 32'({misalign_o, bus_err_o}), 32'd0);
    check("rst_req", 32'({dmem_req_o, dmem_we_o}), 32'd0);
    check("rst_addr", dmem_addr_o, 32'd0);
    check("rst_be", 32'(dmem_be_o), 32'd0);
    check("rst_wdata", dmem_wdata_o, 32'd0);
    reset_i = 1'b0;

    run_op(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0, 5'd0, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 2, 0, 32'h80FF_0000, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 2, 0, 32'h80FF_0000, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hABCD_5678, 5'd3, 1'b1, 2, 0, 32'h0, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd4, 1'b1, 1, 1, 32'h1234_5678, 1'b1, 1'b0);
    run_op(1'b1, 1'b0, 3'b101, 32'h0000_0502, 32'h0, 5'd6, 1'b1, 1, 2, 32'hF00D_0000, 1'b0, 1'b1);
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_0602, 32'h0, 5'd8, 1'b1, 0, 0, 32'h8001_0000, 1'b0, 1'b0);

    // Reset during REQ drops the request on the next cycle.
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd2, 1'b1);
    @(negedge clk);
    idle_inputs();
    check("rreq_up", 32'(dmem_req_o), 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("rreq_drop", 32'(dmem_req_o), 32'd0);
    check("rreq_idle", 32'(ready_o), 32'd1);

    // Reset during WAIT returns to IDLE; a late rvalid is ignored.
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd2, 1'b1);
    @(negedge clk);
    idle_inputs();
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    check("rwait_busy", 32'(ready_o), 32'd0);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("rwait_req", 32'(dmem_req_o), 32'd0);
    check("rwait_idle", 32'(ready_o), 32'd1);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    check("late_rvalid", 32'(valid_o), 32'd0);
    check("late_we", 32'(rd_write_en_o), 32'd0);
    check("late_data", rd_data_o, 32'd0);

    for (int i = 0; i < 40; i++) begin
      kind  = $urandom_range(0, 3);
      ld    = (kind == 1) || (kind == 3);
      st    = (kind == 2) || (kind == 3);
      sz    = 3'($urandom_range(0, 7));
      n     = nbytes_of(sz);
      addr  = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr - (addr % n);
      sdata = $urandom;
      rdata = $urandom;
      err   = ($urandom_range(0, 7) == 0);
      run_op(ld, st, sz, addr, sdata, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3), rdata, err, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
